// File: rtl/fillant_obs_chain_if.sv
// Snapshot request and serial-output handshake between the antenna observer
// chain and its consumer.
interface fillant_obs_chain_if;
  logic START;
  logic BUSY;
  logic SO;
  logic SO_VLD;
  logic DONE;

  modport master (
    output START,
    input  BUSY,
    input  SO,
    input  SO_VLD,
    input  DONE
  );

  modport slave (
    input  START,
    output BUSY,
    output SO,
    output SO_VLD,
    output DONE
  );
endinterface

// File: rtl/fillant_obs_chain.sv
// Antenna-tap observer: synchronise and debounce each channel, keep sticky
// toggle flags, and shift a {flags, levels} snapshot out serially on request.
module fillant_obs_chain #(
  parameter int NCH  = 8,
  parameter int DEB  = 4,
  parameter int SYNC = 2
) (
  input  logic               C,
  input  logic               RN,
  input  logic [NCH-1:0]     ANT1,
  fillant_obs_chain_if.slave bus,
  output logic [NCH-1:0]     LVL,
  output logic               EVT
);

  localparam int CW = $clog2(DEB + 1);
  localparam int SW = 2 * NCH;
  localparam int BW = (SW > 1) ? $clog2(SW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SHIFT,
    FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NCH-1:0]  sync_q [SYNC];
  logic [NCH-1:0]  samp;
  logic [CW-1:0]   cnt [NCH];
  logic [NCH-1:0]  accept;
  logic [NCH-1:0]  flags;
  logic [SW-1:0]   shreg;
  logic [BW-1:0]   bit_cnt;
  logic            capt;
  logic            shift;
  logic            last_bit;

  // Synchroniser chain; nothing downstream sees ANT1 directly.
  always_ff @(posedge C) begin
    if (!RN) begin
      for (int unsigned k = 0; k < SYNC; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= ANT1;
      for (int unsigned k = 1; k < SYNC; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign samp = sync_q[SYNC-1];

  // A channel accepts on the DEB-th consecutive differing sample, so the
  // counter never climbs past DEB-1 and cannot wrap.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      accept[i] = (samp[i] != LVL[i]) && (cnt[i] == CW'(DEB - 1));
    end
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      LVL <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (samp[i] == LVL[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i] <= '0;
          LVL[i] <= samp[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign capt     = (state == CAPT);
  assign shift    = (state == SHIFT);
  assign last_bit = (bit_cnt == BW'(SW - 1));

  // Capture clears the flags, but a same-cycle acceptance re-sets its flag.
  always_ff @(posedge C) begin
    if (!RN) begin
      flags <= '0;
      EVT   <= 1'b0;
    end else begin
      flags <= (flags & ~{NCH{capt}}) | accept;
      EVT   <= |flags;
    end
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.START) state_nxt = CAPT;
      CAPT:    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (capt) begin
      shreg   <= {flags, LVL};
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= {shreg[SW-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.BUSY   = (state != IDLE);
    bus.DONE   = (state == FIN);
    bus.SO_VLD = shift;
    bus.SO     = shift & shreg[SW-1];
  end

endmodule
